// File: rtl/visca_reply_rx.sv
// VISCA reply parser: frames camera replies, classifies ACK/Completion/Error/inquiry,
// and double-buffers inquiry payload. Optional inter-byte timeout: VISCA_RX_TIMEOUT_EN.
module visca_reply_rx #(
    parameter int CAM_ADDR    = 1,
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       ack_stb,
    output logic       cmpl_stb,
    output logic       err_stb,
    output logic       inq_stb,
    output logic [3:0] socket,
    output logic [7:0] err_code,
    output logic [3:0] pay_len,
    input  logic [3:0] pay_addr,
    output logic [7:0] pay_data,
    output logic       drop_stb
);

    // state   | meaning
    // IDLE    | waiting for the reply header
    // BODY    | collecting packet bytes until 0xFF
    // DISCARD | skipping an oversized packet until 0xFF
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BODY    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    localparam logic [7:0] HDR      = 8'(8'h80 | ((CAM_ADDR + 8) << 4));
    localparam logic [7:0] TERM     = 8'hFF;
    localparam logic [3:0] LAST_CNT = 4'(MAX_LEN - 1);

    logic [1:0] state;
    logic [3:0] count;
    logic [7:0] byte1;
    logic       bank_sel;
    logic [7:0] bank0 [16];
    logic [7:0] bank1 [16];
    logic [7:0] shadow_b2;
    logic       is_ack, is_cmpl, is_inq, is_err;
    logic       store_byte;

    // count holds bytes received so far, so the packet length with 0xFF is count+1
    always_comb begin
        is_ack  = (count == 4'd2) && (byte1[7:4] == 4'h4);
        is_cmpl = (count == 4'd2) && (byte1[7:4] == 4'h5) && (byte1[3:0] != 4'h0);
        is_inq  = (count >= 4'd2) && (byte1 == 8'h50);
        is_err  = (count == 4'd3) && (byte1[7:4] == 4'h6);
    end

    assign store_byte = rx_valid && (state == S_BODY) && (rx_data != TERM) && (count != LAST_CNT);
    assign pay_data   = bank_sel ? bank1[pay_addr] : bank0[pay_addr];
    assign shadow_b2  = bank_sel ? bank0[0] : bank1[0];

`ifdef VISCA_RX_TIMEOUT_EN
    localparam int GW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYC - 1);
    logic [GW-1:0] gap;
    logic          gap_hit;

    assign gap_hit = (state != S_IDLE) && (gap == GAP_LAST);

    always_ff @(posedge clk) begin
        if (rst || rx_valid || state == S_IDLE || gap_hit) gap <= '0;
        else gap <= gap + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= 4'd0;
            byte1    <= 8'h00;
            bank_sel <= 1'b0;
            ack_stb  <= 1'b0;
            cmpl_stb <= 1'b0;
            err_stb  <= 1'b0;
            inq_stb  <= 1'b0;
            drop_stb <= 1'b0;
            socket   <= 4'd0;
            err_code <= 8'h00;
            pay_len  <= 4'd0;
        end else begin
            ack_stb  <= 1'b0;
            cmpl_stb <= 1'b0;
            err_stb  <= 1'b0;
            inq_stb  <= 1'b0;
            drop_stb <= 1'b0;
            if (rx_valid) begin
                case (state)
                    S_IDLE: begin
                        if (rx_data == HDR) begin
                            state <= S_BODY;
                            count <= 4'd1;
                        end else if (rx_data != TERM) begin
                            drop_stb <= 1'b1;
                        end
                    end
                    S_BODY: begin
                        if (rx_data == TERM) begin
                            state <= S_IDLE;
                            if (is_ack) begin
                                ack_stb <= 1'b1;
                                socket  <= byte1[3:0];
                            end else if (is_cmpl) begin
                                cmpl_stb <= 1'b1;
                                socket   <= byte1[3:0];
                            end else if (is_inq) begin
                                inq_stb  <= 1'b1;
                                pay_len  <= count - 4'd2;
                                bank_sel <= ~bank_sel;
                            end else if (is_err) begin
                                err_stb  <= 1'b1;
                                socket   <= byte1[3:0];
                                err_code <= shadow_b2;
                            end else begin
                                drop_stb <= 1'b1;
                            end
                        end else if (count == LAST_CNT) begin
                            state    <= S_DISCARD;
                            drop_stb <= 1'b1;
                        end else begin
                            if (count == 4'd1) byte1 <= rx_data;
                            count <= count + 4'd1;
                        end
                    end
                    S_DISCARD: begin
                        if (rx_data == TERM) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
`ifdef VISCA_RX_TIMEOUT_EN
            else if (gap_hit) begin
                state <= S_IDLE;
                if (state == S_BODY) drop_stb <= 1'b1;
            end
`endif
        end
    end

    // payload lands in the bank not currently visible on pay_data
    always_ff @(posedge clk) begin
        if (store_byte && count >= 4'd2) begin
            if (bank_sel) bank0[count - 4'd2] <= rx_data;
            else          bank1[count - 4'd2] <= rx_data;
        end
    end

endmodule

// File: tb/tb_visca_reply_rx.sv
// Bench for visca_reply_rx: packet-level reference model checked every cycle, plus literal spot checks.
module tb_visca_reply_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       ack_stb, cmpl_stb, err_stb, inq_stb, drop_stb;
    logic [3:0] socket, pay_len;
    logic [7:0] err_code, pay_data;
    logic [3:0] pay_addr = 4'd0;

    visca_reply_rx dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .ack_stb(ack_stb), .cmpl_stb(cmpl_stb), .err_stb(err_stb), .inq_stb(inq_stb),
        .socket(socket), .err_code(err_code), .pay_len(pay_len),
        .pay_addr(pay_addr), .pay_data(pay_data), .drop_stb(drop_stb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_ack = 0, n_cmpl = 0, n_err = 0, n_inq = 0, n_drop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: whole-packet view of the byte stream
    logic [7:0] pkt[$];
    bit         m_in, m_disc;
    logic       e_ack, e_cmpl, e_err, e_inq, e_drop;
    logic [3:0] e_socket, e_len;
    logic [7:0] e_code;
    logic [7:0] e_buf [16];

    task automatic model_quiet();
        e_ack = 0; e_cmpl = 0; e_err = 0; e_inq = 0; e_drop = 0;
    endtask

    task automatic model_reset();
        model_quiet();
        e_socket = 0; e_code = 0; e_len = 0;
        m_in = 0; m_disc = 0; pkt.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        int n;
        logic [7:0] b1;
        model_quiet();
        if (m_disc) begin
            if (b == 8'hFF) m_disc = 0;
        end else if (!m_in) begin
            if (b == 8'h90) begin
                m_in = 1;
                pkt.delete();
                pkt.push_back(b);
            end else if (b != 8'hFF) e_drop = 1;
        end else if (b == 8'hFF) begin
            m_in = 0;
            n = pkt.size() + 1;
            b1 = (pkt.size() > 1) ? pkt[1] : 8'h00;
            if (n == 3 && b1[7:4] == 4'h4) begin
                e_ack = 1; e_socket = b1[3:0];
            end else if (n == 3 && b1[7:4] == 4'h5 && b1[3:0] != 0) begin
                e_cmpl = 1; e_socket = b1[3:0];
            end else if (n >= 3 && b1 == 8'h50) begin
                e_inq = 1; e_len = 4'(n - 3);
                for (int i = 0; i < n - 3; i++) e_buf[i] = pkt[i + 2];
            end else if (n == 4 && b1[7:4] == 4'h6) begin
                e_err = 1; e_socket = b1[3:0]; e_code = pkt[2];
            end else e_drop = 1;
        end else if (pkt.size() == 15) begin
            m_in = 0; m_disc = 1; e_drop = 1;
        end else pkt.push_back(b);
    endtask

    // per-cycle comparison against the model
    always @(posedge clk) begin
        #2;
        chk("ack_stb", 32'(ack_stb), 32'(e_ack));
        chk("cmpl_stb", 32'(cmpl_stb), 32'(e_cmpl));
        chk("err_stb", 32'(err_stb), 32'(e_err));
        chk("inq_stb", 32'(inq_stb), 32'(e_inq));
        chk("drop_stb", 32'(drop_stb), 32'(e_drop));
        chk("socket", 32'(socket), 32'(e_socket));
        chk("err_code", 32'(err_code), 32'(e_code));
        chk("pay_len", 32'(pay_len), 32'(e_len));
        if (pay_addr < e_len) chk("pay_data", 32'(pay_data), 32'(e_buf[pay_addr]));
        n_ack  += int'(ack_stb);
        n_cmpl += int'(cmpl_stb);
        n_err  += int'(err_stb);
        n_inq  += int'(inq_stb);
        n_drop += int'(drop_stb);
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        cyc++;
        rst = 0; rx_valid = 1; rx_data = b; pay_addr = 4'(cyc);
        model_byte(b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            rst = 0; rx_valid = 0; pay_addr = 4'(cyc);
            model_quiet();
        end
    endtask

    task automatic send_seq(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
        idle(2);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1; rx_valid = 0;
            model_reset();
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
        @(negedge clk);
        rx_valid = 0; pay_addr = a;
        model_quiet();
        #1 chk(name, 32'(pay_data), 32'(exp));
    endtask

    task automatic clr_counts();
        n_ack = 0; n_cmpl = 0; n_err = 0; n_inq = 0; n_drop = 0;
    endtask

    logic [7:0] seq[$];

    initial begin
        model_reset();
        do_reset(3);
        idle(1);
        chk("reset socket", 32'(socket), 0);
        chk("reset pay_len", 32'(pay_len), 0);
        chk("reset drop", 32'(drop_stb), 0);

        clr_counts();
        seq = {8'h90, 8'h41, 8'hFF, 8'h90, 8'h51, 8'hFF};
        send_seq(seq);
        chk("ack/cmpl acks", 32'(n_ack), 1);
        chk("ack/cmpl cmpls", 32'(n_cmpl), 1);
        chk("ack/cmpl drops", 32'(n_drop), 0);
        chk("ack/cmpl socket", 32'(socket), 1);

        seq = {8'h90, 8'h62, 8'h41, 8'hFF};
        send_seq(seq);
        chk("err socket", 32'(socket), 2);
        chk("err code", 32'(err_code), 32'h41);

        seq = {8'h90, 8'h50, 8'h00, 8'h00, 8'h04, 8'h00, 8'hFF};
        send_seq(seq);
        chk("zoom pay_len", 32'(pay_len), 4);
        rd(4'd2, 8'h04, "zoom pay[2]");
        rd(4'd3, 8'h00, "zoom pay[3]");
        seq = {8'h90, 8'h50, 8'h02};
        foreach (seq[i]) send(seq[i]);
        rd(4'd2, 8'h04, "inflight pay[2]");
        chk("inflight pay_len", 32'(pay_len), 4);
        send(8'hFF);
        idle(2);
        chk("short pay_len", 32'(pay_len), 1);
        rd(4'd0, 8'h02, "short pay[0]");

        clr_counts();
        seq = {8'hA0, 8'h41, 8'hFF, 8'h90, 8'h42, 8'hFF};
        send_seq(seq);
        chk("badhdr drops", 32'(n_drop), 2);
        chk("badhdr acks", 32'(n_ack), 1);
        chk("badhdr socket", 32'(socket), 2);

        clr_counts();
        seq = {8'h90};
        for (int i = 1; i <= 20; i++) seq.push_back(8'(i));
        seq.push_back(8'hFF);
        send_seq(seq);
        chk("overflow drops", 32'(n_drop), 1);
        chk("overflow others", 32'(n_ack + n_cmpl + n_err + n_inq), 0);
        seq = {8'h90, 8'h43, 8'hFF};
        send_seq(seq);
        chk("post-overflow socket", 32'(socket), 3);

        clr_counts();
        seq = {8'h90, 8'h50};
        for (int i = 0; i < 13; i++) seq.push_back(8'(8'hA0 + i));
        seq.push_back(8'hFF);
        send_seq(seq);
        chk("maxlen inq", 32'(n_inq), 1);
        chk("maxlen pay_len", 32'(pay_len), 13);
        rd(4'd12, 8'hAC, "maxlen pay[12]");

        clr_counts();
        seq = {8'h90, 8'h50, 8'hFF, 8'h90, 8'hFF, 8'h90, 8'h41, 8'h00, 8'hFF,
               8'h90, 8'h50, 8'hFF, 8'h90, 8'h90, 8'hFF, 8'h90, 8'h65, 8'h02, 8'hFF};
        send_seq(seq);
        chk("misc inqs", 32'(n_inq), 2);
        chk("misc drops", 32'(n_drop), 3);
        chk("misc pay_len", 32'(pay_len), 0);
        chk("misc err_code", 32'(err_code), 32'h02);

        clr_counts();
        send(8'h90);
        send(8'h41);
        do_reset(1);
        send(8'hFF);
        idle(3);
        chk("rst mid-packet strobes", 32'(n_ack + n_cmpl + n_err + n_inq + n_drop), 0);
        chk("rst mid-packet socket", 32'(socket), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
